// File: rtl/u_spi_sample_fifo.sv
// SPI mode-0 slave byte receiver feeding a small FIFO drained one sample per osr tick to the DAC.
// Capture 3 clk after raw sclk rise, push 1 clk later; no backpressure: full drops (ovf), empty holds (unf).
module u_spi_sample_fifo #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter logic [7:0]  RESET_CODE = 8'h80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_b,
    input  logic                  mosi,
    input  logic [1:0]            osr_sel,
    input  logic                  clr_flags,
    output logic [7:0]            d_out,
    output logic                  sample_stb,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  ovf,
    output logic                  unf
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    logic              sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic              cs_s1_q, cs_s2_q;
    logic              mosi_s1_q, mosi_s2_q;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              push_q, push_d;
    logic [4:0]        tick_cnt_q, tick_cnt_d, period_m1;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        dout_q, dout_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              sclk_rise, tick, full, empty, pop, wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= cs_b;
            cs_s2_q   <= cs_s1_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    // Deasserted chip select discards any partial byte by restarting the bit count.
    always_comb begin
        sclk_rise = sclk_s2_q & ~sclk_s3_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        push_d    = 1'b0;
        if (cs_s2_q) begin
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            shift_d   = {shift_q[6:0], mosi_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            push_d    = (bit_cnt_q == 3'd7);
        end
    end

    always_comb begin
        case (osr_sel)
            2'd0:    period_m1 = 5'd3;
            2'd1:    period_m1 = 5'd7;
            2'd2:    period_m1 = 5'd15;
            default: period_m1 = 5'd31;
        endcase
        tick       = (tick_cnt_q >= period_m1);
        tick_cnt_d = tick ? 5'd0 : tick_cnt_q + 5'd1;
    end

    // Pop sees occupancy before this cycle's push, so a full FIFO still accepts on a tick.
    always_comb begin
        empty  = (wptr_q == rptr_q);
        full   = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                 (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
        pop    = tick & ~empty;
        wr_en  = push_q & (~full | pop);
        rptr_d = rptr_q + PW'(pop);
        wptr_d = wptr_q + PW'(wr_en);
        dout_d = pop ? mem_q[rptr_q[PW-2:0]] : dout_q;
        ovf_d  = (push_q & full & ~pop) | (ovf_q & ~clr_flags);
        unf_d  = (tick & empty) | (unf_q & ~clr_flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
            push_q     <= 1'b0;
            tick_cnt_q <= 5'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            dout_q     <= RESET_CODE;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            push_q     <= push_d;
            tick_cnt_q <= tick_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            dout_q     <= dout_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            if (wr_en) mem_q[wptr_q[PW-2:0]] <= shift_q;
        end
    end

    assign d_out      = dout_q;
    assign sample_stb = tick;
    assign fifo_level = wptr_q - rptr_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;
endmodule

// File: tb/tb_u_spi_sample_fifo.sv
// Bench for u_spi_sample_fifo: queue-based reference model checked every cycle plus directed checks.
module tb_u_spi_sample_fifo;
    localparam int DL    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_b = 1'b1;
    logic        mosi = 1'b0;
    logic [1:0]  osr_sel = 2'd0;
    logic        clr_flags = 1'b0;
    logic [7:0]  d_out;
    logic        sample_stb;
    logic [DL:0] fifo_level;
    logic        ovf;
    logic        unf;

    u_spi_sample_fifo #(.DEPTH_LOG2(DL), .RESET_CODE(8'h80)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_b(cs_b), .mosi(mosi),
        .osr_sel(osr_sel), .clr_flags(clr_flags), .d_out(d_out),
        .sample_stb(sample_stb), .fifo_level(fifo_level), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sample queue, period counter, sticky flags.
    logic [7:0] m_q[$];
    logic [7:0] m_dout = 8'h80;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;
    int         m_tcnt = 0;
    int         cyc = 0;
    logic [7:0] sent_b[$];
    int         sent_due[$];

    function automatic int per_of(input logic [1:0] s);
        return 4 << s;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            sent_b.delete();
            sent_due.delete();
            m_dout = 8'h80;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_tcnt = 0;
        end else begin
            bit         tick, push, set_o, set_u;
            logic [7:0] pb;
            cyc++;
            tick  = (m_tcnt >= per_of(osr_sel) - 1);
            push  = 1'b0;
            pb    = 8'd0;
            set_o = 1'b0;
            set_u = 1'b0;
            if (sent_due.size() > 0 && sent_due[0] == cyc) begin
                push = 1'b1;
                pb   = sent_b.pop_front();
                void'(sent_due.pop_front());
            end
            if (tick) begin
                if (m_q.size() > 0) m_dout = m_q.pop_front();
                else set_u = 1'b1;
                m_tcnt = 0;
            end else begin
                m_tcnt++;
            end
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(pb);
                else set_o = 1'b1;
            end
            if (clr_flags) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            m_ovf = m_ovf | set_o;
            m_unf = m_unf | set_u;
        end
    end

    bit chk_en = 1'b0;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("d_out", 32'(d_out), 32'(m_dout));
            chk("level", 32'(fifo_level), m_q.size());
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("unf", 32'(unf), 32'(m_unf));
            chk("stb", 32'(sample_stb), 32'(m_tcnt >= per_of(osr_sel) - 1));
        end
    end

    int ph = 3;

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic frame_start();
        cs_b = 1'b0;
        wait_clk(3);
    endtask

    task automatic frame_end();
        sclk = 1'b0;
        wait_clk(ph);
        cs_b = 1'b1;
        wait_clk(3);
    endtask

    // n MSB-first bits of b; align delays the last rise so its push lands on a tick (osr_sel 0).
    task automatic send_bits(input logic [7:0] b, input int n, input bit align);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            wait_clk(ph);
            if (align && i == 0)
                for (int k = 0; k < 64 && m_tcnt != 0; k++) wait_clk(1);
            sclk = 1'b1;
            if (n == 8 && i == 0) begin
                sent_b.push_back(b);
                sent_due.push_back(cyc + 4);
            end
            wait_clk(ph);
            sclk = 1'b0;
        end
    endtask

    task automatic wait_stb(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!sample_stb && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_stb_seen"}, 32'(sample_stb), 32'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_clk(3);
        chk("rst_dout", 32'(d_out), 32'h80);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_flags", 32'({ovf, unf, sample_stb}), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        chk_en = 1'b1;

        do_reset();
        n = 0;
        while (!sample_stb && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_stb_cycle", n, 32'd4);

        frame_start();
        send_bits(8'hA5, 8, 1'b0);
        frame_end();
        wait_stb("single");
        chk("single_dout", 32'(d_out), 32'hA5);
        chk("single_level", 32'(fifo_level), 32'd0);

        frame_start();
        send_bits(8'h3C, 8, 1'b0);
        frame_end();
        wait_stb("unf_load");
        chk("unf_load_dout", 32'(d_out), 32'h3C);
        clr_flags = 1'b1;
        wait_clk(1);
        clr_flags = 1'b0;
        wait_stb("unf");
        chk("unf_hold_dout", 32'(d_out), 32'h3C);
        chk("unf_set", 32'(unf), 32'd1);

        // Clear flags on the very edge where the push meets a tick on an empty FIFO.
        frame_start();
        send_bits(8'hC3, 8, 1'b1);
        clr_flags = 1'b1;
        wait_clk(1);
        clr_flags = 1'b0;
        @(negedge clk);
        chk("simul_unf", 32'(unf), 32'd1);
        chk("simul_level", 32'(fifo_level), 32'd1);
        frame_end();
        wait_stb("simul");
        chk("simul_dout", 32'(d_out), 32'hC3);

        frame_start();
        send_bits(8'hB0, 5, 1'b0);
        do_reset();
        osr_sel = 2'd3;
        frame_end();
        frame_start();
        send_bits(8'hB0, 5, 1'b0);
        frame_end();
        frame_start();
        send_bits(8'h7E, 8, 1'b0);
        frame_end();
        wait_stb("abort");
        chk("abort_dout", 32'(d_out), 32'h7E);
        chk("abort_level", 32'(fifo_level), 32'd0);

        do_reset();
        frame_start();
        for (int b = 1; b <= 4; b++) send_bits(8'(b), 8, 1'b0);
        frame_end();
        wait_stb("burst_a");
        wait_stb("burst_b");
        chk("burst_dout", 32'(d_out), 32'h04);
        chk("burst_ovf", 32'(ovf), 32'd0);

        // Fast sclk outruns the slowest drain rate so the FIFO must overflow.
        do_reset();
        ph = 1;
        frame_start();
        for (int b = 0; b < 12; b++) send_bits(8'($urandom), 8, 1'b0);
        frame_end();
        chk("ovf_set", 32'(ovf), 32'd1);
        clr_flags = 1'b1;
        wait_clk(1);
        clr_flags = 1'b0;
        @(negedge clk);
        chk("ovf_clr", 32'(ovf), 32'd0);
        ph = 3;

        for (int it = 0; it < 24; it++) begin
            osr_sel = 2'($urandom_range(0, 3));
            ph = $urandom_range(1, 3);
            frame_start();
            n = $urandom_range(1, 3);
            for (int b = 0; b < n; b++) send_bits(8'($urandom), 8, 1'b0);
            if ($urandom_range(0, 3) == 0) send_bits(8'($urandom), $urandom_range(1, 7), 1'b0);
            frame_end();
            if ($urandom_range(0, 2) == 0) begin
                clr_flags = 1'b1;
                wait_clk(1);
                clr_flags = 1'b0;
            end
            wait_clk($urandom_range(0, 40));
        end
        ph = 3;
        wait_clk(80);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
